// File: rtl/uart_cmd_frame_ctrl.sv
// Frames UART command bytes (SYNC, CMD, PAYLOAD, CHK) into target loads
// and start/stop requests for the cracking engine, with an inter-byte timeout.
module uart_cmd_frame_ctrl #(
   parameter int TARGET_BYTES = 16,
   parameter int TIMEOUT_CLKS = 868000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_valid,
   input  logic [7:0]                rx_data,
   input  logic                      engine_busy,
   output logic [8*TARGET_BYTES-1:0] target_out,
   output logic                      target_load,
   output logic                      start_pulse,
   output logic                      stop_pulse,
   output logic                      frame_err,
   output logic [1:0]                err_code,
   output logic                      parsing
);

   localparam int DW = 8 * TARGET_BYTES;
   localparam int IW = $clog2(TARGET_BYTES) + 1;
   localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(TARGET_BYTES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic [1:0] {IDLE, CMD, PAYLOAD, CHK} state_t;

   state_t        state_q, state_d;
   logic [1:0]    cmd_q, cmd_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    xor_q, xor_d;
   logic [DW-1:0] shadow_q, shadow_d;
   logic [DW-1:0] target_q, target_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [TW-1:0] tmo_inc;
   logic          tmo_hit;
   logic          load_q, load_d;
   logic          start_q, start_d;
   logic          stop_q, stop_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;
   logic          parsing_q, parsing_d;

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      idx_d    = idx_q;
      xor_d    = xor_q;
      shadow_d = shadow_q;
      target_d = target_q;
      load_d   = 1'b0;
      start_d  = 1'b0;
      stop_d   = 1'b0;
      err_d    = 1'b0;
      code_d   = code_q;
      tmo_inc  = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);
      // The incoming byte in the detecting cycle pre-empts the timeout
      tmo_hit  = (state_q != IDLE) && !rx_valid && (tmo_inc == TMO_LAST);
      if (rx_valid || state_q == IDLE) tmo_d = '0;
      else tmo_d = tmo_inc;

      if (rx_valid) begin
         unique case (state_q)
            IDLE: begin
               if (rx_data == 8'hA5) state_d = CMD;
            end
            CMD: begin
               cmd_d = rx_data[1:0];
               xor_d = rx_data;
               idx_d = '0;
               case (rx_data)
                  8'h01: state_d = PAYLOAD;
                  8'h02, 8'h03: state_d = CHK;
                  default: begin
                     err_d   = 1'b1;
                     code_d  = 2'd1;
                     state_d = IDLE;
                  end
               endcase
            end
            PAYLOAD: begin
               shadow_d      = shadow_q << 8;
               shadow_d[7:0] = rx_data;
               xor_d         = xor_q ^ rx_data;
               idx_d         = idx_q + IW'(1);
               if (idx_q == IDX_LAST) state_d = CHK;
            end
            CHK: begin
               state_d = IDLE;
               if (rx_data == xor_q) begin
                  case (cmd_q)
                     2'd1: begin
                        target_d = shadow_q;
                        load_d   = 1'b1;
                     end
                     2'd2: start_d = !engine_busy;
                     default: stop_d = 1'b1;
                  endcase
               end else begin
                  err_d  = 1'b1;
                  code_d = 2'd2;
               end
            end
         endcase
      end else if (tmo_hit) begin
         err_d   = 1'b1;
         code_d  = 2'd3;
         state_d = IDLE;
      end
      parsing_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cmd_q     <= '0;
         idx_q     <= '0;
         xor_q     <= '0;
         shadow_q  <= '0;
         target_q  <= '0;
         tmo_q     <= '0;
         load_q    <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= '0;
         parsing_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         idx_q     <= idx_d;
         xor_q     <= xor_d;
         shadow_q  <= shadow_d;
         target_q  <= target_d;
         tmo_q     <= tmo_d;
         load_q    <= load_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         err_q     <= err_d;
         code_q    <= code_d;
         parsing_q <= parsing_d;
      end
   end

   assign target_out  = target_q;
   assign target_load = load_q;
   assign start_pulse = start_q;
   assign stop_pulse  = stop_q;
   assign frame_err   = err_q;
   assign err_code    = code_q;
   assign parsing     = parsing_q;

endmodule
